mcdt_arbiter: RTL

Round-robin burst arbiter for the multi-channel data transfer (MCDT) datapath. It sits between the per-channel slave FIFOs and the MCDT output formatter. Each cycle it picks one non-empty, enabled channel and pops one word from that channel's FIFO. The popped word, tagged with its channel id, is driven on the registered MCDT output one cycle later.

---
 rtl/mcdt_pkg.sv | 18 +
 rtl/mcdt_rr_pick.sv | 35 +++
 rtl/mcdt_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mcdt_pkg.sv
// Shared types and defaults for the MCDT arbiter.
// Imported by the arbiter top and its round-robin picker.
package mcdt_pkg;

   localparam int NUM_CH_DEF = 3;
   localparam int DATA_W_DEF = 32;
   localparam int ID_W_DEF   = 2;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_OWN  = 1'b1
   } arb_state_e;

   typedef logic [3:0] burst_cnt_t;

   localparam burst_cnt_t CNT_MAX = 4'd15;

endpackage

// File: rtl/mcdt_rr_pick.sv
// Rotating-priority search over eligible channels.
// Purely combinational; the search starts at i_ptr.
module mcdt_rr_pick
   import mcdt_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int ID_W   = ID_W_DEF
) (
   input  logic [NUM_CH-1:0] i_elig,
   input  logic [ID_W-1:0]   i_ptr,
   output logic [NUM_CH-1:0] o_gnt,
   output logic [ID_W-1:0]   o_idx,
   output logic              o_found
);

   int w_c;

   // first eligible channel at or after the pointer, wrapping
   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      o_found = 1'b0;
      w_c     = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_c = int'(i_ptr) + k;
         if (w_c >= NUM_CH) w_c = w_c - NUM_CH;
         if (!o_found && i_elig[w_c]) begin
            o_found   = 1'b1;
            o_idx     = ID_W'(w_c);
            o_gnt[w_c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mcdt_arbiter.sv
// Round-robin burst arbiter between channel FIFOs and MCDT output.
// Pops one word per cycle; output is registered one cycle later.
module mcdt_arbiter
   import mcdt_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ID_W   = ID_W_DEF
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic [NUM_CH-1:0]        req_i,
   input  logic [NUM_CH*DATA_W-1:0] data_i,
   input  logic [NUM_CH-1:0]        ch_en_i,
   input  logic [3:0]               burst_len_i,
   output logic [NUM_CH-1:0]        pop_o,
   output logic [DATA_W-1:0]        mcdt_data_o,
   output logic                     mcdt_val_o,
   output logic [ID_W-1:0]          mcdt_id_o
);

   arb_state_e        r_state;
   arb_state_e        w_next_state;
   logic [ID_W-1:0]   r_owner;
   burst_cnt_t        r_cnt;
   logic [ID_W-1:0]   r_ptr;

   logic [NUM_CH-1:0] w_elig;
   logic [NUM_CH-1:0] w_own_oh;
   logic [NUM_CH-1:0] w_gnt;
   logic [ID_W-1:0]   w_idx;
   logic              w_found;
   logic [3:0]        w_eff_len;
   logic              w_keep;
   burst_cnt_t        w_cnt_inc;
   logic [ID_W-1:0]   w_ptr_nxt;
   logic [ID_W-1:0]   w_sel_idx;
   logic [DATA_W-1:0] w_sel_data;
   logic [NUM_CH-1:0] w_pop;

   assign w_elig    = req_i & ch_en_i;
   assign w_own_oh  = NUM_CH'(1) << r_owner;
   assign w_eff_len = (burst_len_i == 4'd0) ? 4'd1 : burst_len_i;
   assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 4'd1;

   // owner stays only while eligible and the burst has room left
   assign w_keep = (r_state == ARB_OWN)
                 && (|(w_own_oh & w_elig))
                 && (({1'b0, r_cnt} + 5'd1) < {1'b0, w_eff_len});

   assign w_ptr_nxt = (w_idx == ID_W'(NUM_CH - 1))
                    ? '0 : w_idx + ID_W'(1);
   assign w_sel_idx = w_keep ? r_owner : w_idx;

   mcdt_rr_pick #(
      .NUM_CH (NUM_CH),
      .ID_W   (ID_W)
   ) u_pick (
      .i_elig  (w_elig),
      .i_ptr   (r_ptr),
      .o_gnt   (w_gnt),
      .o_idx   (w_idx),
      .o_found (w_found)
   );

   // state register
   always_ff @(posedge clk_i) begin
      if (!rstn_i) r_state <= ARB_IDLE;
      else         r_state <= w_next_state;
   end

   // next state: own whenever something is popped
   always_comb begin
      w_next_state = ARB_IDLE;
      if (w_keep || w_found) w_next_state = ARB_OWN;
   end

   // pop strobe: keep owner, else fresh pick, gated by reset
   always_comb begin
      w_pop = '0;
      if (!rstn_i)      w_pop = '0;
      else if (w_keep)  w_pop = w_own_oh;
      else if (w_found) w_pop = w_gnt;
   end

   assign pop_o = w_pop;

   // head word of the popped channel
   always_comb begin
      w_sel_data = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_pop[c]) w_sel_data = data_i[c*DATA_W +: DATA_W];
      end
   end

   // owner, burst count and rotation pointer bookkeeping
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_owner <= '0;
         r_cnt   <= '0;
         r_ptr   <= '0;
      end else if (w_keep) begin
         r_cnt   <= w_cnt_inc;
      end else if (w_found) begin
         r_owner <= w_idx;
         r_cnt   <= '0;
         r_ptr   <= w_ptr_nxt;
      end else begin
         r_cnt   <= '0;
      end
   end

   // registered output; data and id hold when nothing is popped
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         mcdt_val_o  <= 1'b0;
         mcdt_data_o <= '0;
         mcdt_id_o   <= '0;
      end else begin
         mcdt_val_o <= |w_pop;
         if (|w_pop) begin
            mcdt_data_o <= w_sel_data;
            mcdt_id_o   <= w_sel_idx;
         end
      end
   end

endmodule
